// File: rtl/pipeline_debug_port.sv
// pipeline_debug_port: host-side debug/load controller for the pipeline core.
// A single valid/ready command channel covers several operations: IMEM program
// load (single or auto-increment), run/halt control, and register-file or
// data-memory readback. Every accepted command returns exactly one response pulse.
module pipeline_debug_port #(
   parameter int XLEN     = 32,
   parameter int RF_AW    = 5,
   parameter int DMEM_LAT = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             h_valid,
   output logic             h_ready,
   input  logic [2:0]       h_cmd,
   input  logic [XLEN-1:0]  h_addr,
   input  logic [XLEN-1:0]  h_wdata,
   output logic             h_rvalid,
   output logic [XLEN-1:0]  h_rdata,
   output logic             h_err,
   output logic             core_start,
   output logic             imem_we,
   output logic [XLEN-1:0]  imem_addr,
   output logic [XLEN-1:0]  imem_wdata,
   output logic [RF_AW-1:0] rf_ra,
   input  logic [XLEN-1:0]  rf_rdata,
   output logic             dm_re,
   output logic [XLEN-1:0]  dm_addr,
   input  logic [XLEN-1:0]  dm_rdata
);

   localparam logic [2:0] CMD_LOAD     = 3'b000;
   localparam logic [2:0] CMD_LOADNEXT = 3'b001;
   localparam logic [2:0] CMD_RDREG    = 3'b010;
   localparam logic [2:0] CMD_RDMEM    = 3'b011;
   localparam logic [2:0] CMD_RUN      = 3'b100;
   localparam logic [2:0] CMD_HALT     = 3'b101;

   // Memory-wait counter only needs to reach DMEM_LAT-1.
   localparam int CW = (DMEM_LAT > 1) ? $clog2(DMEM_LAT) : 1;

   typedef enum logic [1:0] {S_IDLE, S_EXEC, S_MEMWAIT, S_RESP} state_t;

   state_t           state_q;
   logic [2:0]       cmd_q;
   logic             err_q;
   logic             run_q;
   logic [XLEN-1:0]  ptr_q;
   logic [CW-1:0]    cnt_q;
   logic             h_rvalid_q;
   logic [XLEN-1:0]  h_rdata_q;
   logic             h_err_q;
   logic             imem_we_q;
   logic [XLEN-1:0]  imem_addr_q;
   logic [XLEN-1:0]  imem_wdata_q;
   logic [RF_AW-1:0] rf_ra_q;
   logic             dm_re_q;
   logic [XLEN-1:0]  dm_addr_q;

   logic             accept_d;
   logic             rej_d;

   // A rejected command has no side effects: no strobes, pointer and run flag untouched.
   function automatic logic cmd_rejected(input logic [2:0] cmd,
                                         input logic [XLEN-1:0] addr,
                                         input logic running);
      logic rej;
      rej = 1'b0;
      case (cmd)
         CMD_LOAD:          rej = running || (addr[1:0] != 2'b00);
         CMD_LOADNEXT:      rej = running;
         CMD_RDREG:         rej = ((addr >> RF_AW) != '0);
         CMD_RDMEM:         rej = (addr[1:0] != 2'b00);
         CMD_RUN, CMD_HALT: rej = 1'b0;
         default:           rej = 1'b1;
      endcase
      return rej;
   endfunction

   // Accept decode; the run flag and pointer cannot change while IDLE, so the
   // rejection decided here equals the one the EXEC state acts on.
   always_comb begin
      accept_d = h_valid && (state_q == S_IDLE);
      rej_d    = cmd_rejected(h_cmd, h_addr, run_q);
   end

   // Command FSM with registered strobes, addresses and response.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         cmd_q        <= '0;
         err_q        <= 1'b0;
         run_q        <= 1'b0;
         ptr_q        <= '0;
         cnt_q        <= '0;
         h_rvalid_q   <= 1'b0;
         h_rdata_q    <= '0;
         h_err_q      <= 1'b0;
         imem_we_q    <= 1'b0;
         imem_addr_q  <= '0;
         imem_wdata_q <= '0;
         rf_ra_q      <= '0;
         dm_re_q      <= 1'b0;
         dm_addr_q    <= '0;
      end else begin
         imem_we_q <= 1'b0;
         dm_re_q   <= 1'b0;
         case (state_q)
            // accept: capture the command and launch the strobes seen during EXEC
            S_IDLE: begin
               if (accept_d) begin
                  cmd_q   <= h_cmd;
                  err_q   <= rej_d;
                  state_q <= S_EXEC;
                  if (!rej_d) begin
                     case (h_cmd)
                        CMD_LOAD: begin
                           imem_we_q    <= 1'b1;
                           imem_addr_q  <= h_addr;
                           imem_wdata_q <= h_wdata;
                           ptr_q        <= h_addr + XLEN'(4);
                        end
                        CMD_LOADNEXT: begin
                           imem_we_q    <= 1'b1;
                           imem_addr_q  <= ptr_q;
                           imem_wdata_q <= h_wdata;
                           ptr_q        <= ptr_q + XLEN'(4);
                        end
                        CMD_RDREG: rf_ra_q <= h_addr[RF_AW-1:0];
                        CMD_RDMEM: begin
                           dm_re_q   <= 1'b1;
                           dm_addr_q <= h_addr;
                        end
                        default: ;
                     endcase
                  end
               end
            end
            // EXEC: run-flag update, register readback, or hand off to the memory wait
            S_EXEC: begin
               cnt_q <= '0;
               if (!err_q && (cmd_q == CMD_RDMEM)) begin
                  state_q <= S_MEMWAIT;
               end else begin
                  state_q    <= S_RESP;
                  h_rvalid_q <= 1'b1;
                  h_err_q    <= err_q;
                  h_rdata_q  <= (!err_q && (cmd_q == CMD_RDREG) && (rf_ra_q != '0))
                                ? rf_rdata : '0;
                  if (!err_q && (cmd_q == CMD_RUN))  run_q <= 1'b1;
                  if (!err_q && (cmd_q == CMD_HALT)) run_q <= 1'b0;
               end
            end
            // MEMWAIT: read data arrives DMEM_LAT cycles after the dm_re strobe
            S_MEMWAIT: begin
               if (cnt_q == CW'(DMEM_LAT - 1)) begin
                  state_q    <= S_RESP;
                  h_rvalid_q <= 1'b1;
                  h_err_q    <= 1'b0;
                  h_rdata_q  <= dm_rdata;
               end else begin
                  cnt_q <= cnt_q + CW'(1);
               end
            end
            // RESP: one-cycle response pulse, then back to accepting
            S_RESP: begin
               state_q    <= S_IDLE;
               h_rvalid_q <= 1'b0;
               h_rdata_q  <= '0;
               h_err_q    <= 1'b0;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign h_ready    = (state_q == S_IDLE);
   assign h_rvalid   = h_rvalid_q;
   assign h_rdata    = h_rdata_q;
   assign h_err      = h_err_q;
   assign core_start = run_q;
   assign imem_we    = imem_we_q;
   assign imem_addr  = imem_addr_q;
   assign imem_wdata = imem_wdata_q;
   assign rf_ra      = rf_ra_q;
   assign dm_re      = dm_re_q;
   assign dm_addr    = dm_addr_q;

endmodule

// File: tb/tb_pipeline_debug_port.sv
// Testbench for pipeline_debug_port: cycle-indexed expectation model plus
// literal pins for the directed scenarios.
`timescale 1ns/1ps
module tb_pipeline_debug_port;

   localparam int XLEN  = 32;
   localparam int RF_AW = 5;
   localparam int LAT   = 3;
   localparam int MAXC  = 2048;

   localparam logic [2:0] C_LOAD = 3'b000, C_LDNX = 3'b001, C_RDREG = 3'b010;
   localparam logic [2:0] C_RDMEM = 3'b011, C_RUN = 3'b100, C_HALT = 3'b101;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic             rst_n;
   logic             h_valid, h_ready, h_rvalid, h_err, core_start, imem_we, dm_re;
   logic [2:0]       h_cmd;
   logic [XLEN-1:0]  h_addr, h_wdata, h_rdata, imem_addr, imem_wdata, rf_rdata, dm_addr, dm_rdata;
   logic [RF_AW-1:0] rf_ra;

   pipeline_debug_port #(.XLEN(XLEN), .RF_AW(RF_AW), .DMEM_LAT(LAT)) dut (
      .clk(clk), .rst_n(rst_n),
      .h_valid(h_valid), .h_ready(h_ready), .h_cmd(h_cmd), .h_addr(h_addr), .h_wdata(h_wdata),
      .h_rvalid(h_rvalid), .h_rdata(h_rdata), .h_err(h_err), .core_start(core_start),
      .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
      .rf_ra(rf_ra), .rf_rdata(rf_rdata),
      .dm_re(dm_re), .dm_addr(dm_addr), .dm_rdata(dm_rdata)
   );

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_err    = 0;

   // register file model: x0 holds garbage that the port must mask to 0
   logic [31:0] regs [0:31];
   assign rf_rdata = regs[rf_ra];

   function automatic logic [31:0] memf(input logic [31:0] a);
      return (a == 32'h40) ? 32'h0000_1234 : (a ^ 32'hA5A5_0000);
   endfunction

   // expectations indexed by cycle
   bit          e_busy [MAXC];
   bit          e_rv   [MAXC];
   bit          e_err  [MAXC];
   bit          e_we   [MAXC];
   bit          e_dre  [MAXC];
   bit          e_start[MAXC];
   bit          p_v    [MAXC];
   logic [31:0] e_rd [MAXC];
   logic [31:0] e_ia [MAXC];
   logic [31:0] e_iw [MAXC];
   logic [31:0] e_da [MAXC];
   logic [31:0] p_a  [MAXC];

   logic        m_run;
   logic [31:0] m_ptr;
   int          next_free;
   int          last_acc;

   logic [31:0] q_ia[$];
   logic [31:0] q_iw[$];
   logic [31:0] q_rd[$];
   bit          q_err[$];
   int          q_rcyc[$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // data memory: answers exactly LAT cycles after dm_re, garbage otherwise
   always @(posedge clk) begin
      #1;
      if (cyc < MAXC && p_v[cyc]) dm_rdata = memf(p_a[cyc]);
      else                         dm_rdata = 32'hBADC_AFE0;
   end

   // per-cycle compare against the model
   always @(negedge clk) begin
      if (rst_n === 1'b1 && cyc < MAXC) begin
         chk("h_ready", {31'b0, h_ready}, {31'b0, !e_busy[cyc]});
         chk("h_rvalid", {31'b0, h_rvalid}, {31'b0, e_rv[cyc]});
         if (e_rv[cyc]) begin
            chk("h_rdata", h_rdata, e_rd[cyc]);
            chk("h_err", {31'b0, h_err}, {31'b0, e_err[cyc]});
         end
         chk("imem_we", {31'b0, imem_we}, {31'b0, e_we[cyc]});
         if (e_we[cyc]) begin
            chk("imem_addr", imem_addr, e_ia[cyc]);
            chk("imem_wdata", imem_wdata, e_iw[cyc]);
         end
         chk("dm_re", {31'b0, dm_re}, {31'b0, e_dre[cyc]});
         if (e_dre[cyc]) chk("dm_addr", dm_addr, e_da[cyc]);
         chk("core_start", {31'b0, core_start}, {31'b0, e_start[cyc]});
         if (imem_we === 1'b1) begin q_ia.push_back(imem_addr); q_iw.push_back(imem_wdata); end
         if (h_rvalid === 1'b1) begin
            q_rd.push_back(h_rdata); q_err.push_back(h_err); q_rcyc.push_back(cyc);
         end
         if (dm_re === 1'b1 && cyc + LAT < MAXC) begin
            p_v[cyc+LAT] = 1'b1;
            p_a[cyc+LAT] = dm_addr;
         end
      end
   end

   task automatic set_start(input int from, input bit v);
      for (int k = from; k < MAXC; k++) e_start[k] = v;
   endtask

   task automatic clr_obs();
      q_ia.delete(); q_iw.delete(); q_rd.delete(); q_err.delete(); q_rcyc.delete();
   endtask

   task automatic wait_idle();
      while (cyc < next_free) begin @(posedge clk); #1; end
   endtask

   // drive one command for one cycle and record what it must produce
   task automatic issue(input logic [2:0] c, input logic [31:0] ad, input logic [31:0] wd);
      int a, resp;
      bit rej, misaligned;
      logic [31:0] rd;
      wait_idle();
      a = cyc;
      last_acc = a;
      h_valid = 1'b1; h_cmd = c; h_addr = ad; h_wdata = wd;
      misaligned = (ad % 4) != 0;
      rd = 32'h0;
      resp = a + 2;
      if (c == C_LOAD)       rej = m_run || misaligned;
      else if (c == C_LDNX)  rej = m_run;
      else if (c == C_RDREG) rej = ad >= (32'd1 << RF_AW);
      else if (c == C_RDMEM) rej = misaligned;
      else                   rej = (c > C_HALT);
      if (!rej) begin
         if (c == C_LOAD || c == C_LDNX) begin
            e_we[a+1] = 1'b1;
            e_ia[a+1] = (c == C_LOAD) ? ad : m_ptr;
            e_iw[a+1] = wd;
            m_ptr     = e_ia[a+1] + 32'd4;
         end else if (c == C_RDREG) begin
            rd = (ad == 0) ? 32'h0 : regs[ad];
         end else if (c == C_RDMEM) begin
            e_dre[a+1] = 1'b1;
            e_da[a+1]  = ad;
            rd   = memf(ad);
            resp = a + 2 + LAT;
         end else if (c == C_RUN) begin
            m_run = 1'b1; set_start(a + 2, 1'b1);
         end else begin
            m_run = 1'b0; set_start(a + 2, 1'b0);
         end
      end
      e_rv[resp]  = 1'b1;
      e_rd[resp]  = rd;
      e_err[resp] = rej;
      for (int k = a + 1; k <= resp; k++) e_busy[k] = 1'b1;
      next_free = resp + 1;
      @(posedge clk); #1;
      h_valid = 1'b0; h_cmd = 3'b111; h_addr = 32'hFFFF_FFFF; h_wdata = 32'hA5A5_A5A5;
   endtask

   // assert reset now and forget everything the model expected from here on
   task automatic hard_reset();
      int r;
      rst_n = 1'b0;
      r = cyc;
      for (int k = r; k < MAXC; k++) begin
         e_busy[k] = 0; e_rv[k] = 0; e_err[k] = 0; e_we[k] = 0;
         e_dre[k] = 0; e_start[k] = 0; p_v[k] = 0;
      end
      m_run = 1'b0;
      m_ptr = 32'h0;
      next_free = r;
      #1;
      chk("rst h_ready", {31'b0, h_ready}, 32'h1);
      chk("rst h_rvalid", {31'b0, h_rvalid}, 32'h0);
      chk("rst h_rdata", h_rdata, 32'h0);
      chk("rst h_err", {31'b0, h_err}, 32'h0);
      chk("rst core_start", {31'b0, core_start}, 32'h0);
      chk("rst imem_we", {31'b0, imem_we}, 32'h0);
      chk("rst imem_addr", imem_addr, 32'h0);
      chk("rst imem_wdata", imem_wdata, 32'h0);
      chk("rst rf_ra", {27'b0, rf_ra}, 32'h0);
      chk("rst dm_re", {31'b0, dm_re}, 32'h0);
      chk("rst dm_addr", dm_addr, 32'h0);
   endtask

   task automatic release_reset();
      @(posedge clk); #1;
      rst_n = 1'b1;
      next_free = cyc;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 32; i++) regs[i] = 32'h1000_0000 + 32'h11 * i;
      regs[0] = 32'hFFFF_0000;
      regs[5] = 32'hDEAD_BEEF;
      rst_n = 1'b0; h_valid = 1'b0; h_cmd = 3'b0; h_addr = 32'h0; h_wdata = 32'h0;
      m_run = 1'b0; m_ptr = 32'h0; next_free = 0; last_acc = 0;

      @(posedge clk); #1;
      hard_reset();
      @(posedge clk); #1;
      release_reset();

      // single LOAD
      clr_obs();
      issue(C_LOAD, 32'h0, 32'h0050_0093);
      wait_idle();
      chk("load1 count", q_ia.size(), 32'd1);
      chk("load1 addr", q_ia[0], 32'h0);
      chk("load1 data", q_iw[0], 32'h0050_0093);
      chk("load1 latency", q_rcyc[0] - last_acc, 32'd2);
      chk("load1 err", {31'b0, q_err[0]}, 32'h0);

      // LOAD + 3x LOADNEXT
      clr_obs();
      issue(C_LOAD, 32'h100, 32'h1111_0001);
      issue(C_LDNX, 32'h0, 32'h1111_0002);
      issue(C_LDNX, 32'h0, 32'h1111_0003);
      issue(C_LDNX, 32'h0, 32'h1111_0004);
      wait_idle();
      chk("seq addr0", q_ia[0], 32'h100);
      chk("seq addr1", q_ia[1], 32'h104);
      chk("seq addr2", q_ia[2], 32'h108);
      chk("seq addr3", q_ia[3], 32'h10C);
      chk("seq responses", q_rd.size(), 32'd4);

      // RUN blocks loads but not reads; HALT clears
      issue(C_RUN, 32'h0, 32'h0);
      wait_idle();
      chk("run core_start", {31'b0, core_start}, 32'h1);
      clr_obs();
      issue(C_LOAD, 32'h300, 32'h2222_0000);
      issue(C_LDNX, 32'h0, 32'h2222_0001);
      issue(C_RDMEM, 32'h40, 32'h0);
      wait_idle();
      chk("run load err", {31'b0, q_err[0]}, 32'h1);
      chk("run loadnext err", {31'b0, q_err[1]}, 32'h1);
      chk("run no imem_we", q_ia.size(), 32'd0);
      chk("run rdmem data", q_rd[2], 32'h1234);
      issue(C_HALT, 32'h0, 32'h0);
      wait_idle();
      chk("halt core_start", {31'b0, core_start}, 32'h0);

      // register readback
      clr_obs();
      issue(C_RDREG, 32'h0, 32'h0);
      issue(C_RDREG, 32'h5, 32'h0);
      issue(C_RDREG, 32'h20, 32'h0);
      issue(C_RDREG, 32'h1F, 32'h0);
      wait_idle();
      chk("rdreg0", q_rd[0], 32'h0);
      chk("rdreg5", q_rd[1], 32'hDEAD_BEEF);
      chk("rdreg32 err", {31'b0, q_err[2]}, 32'h1);
      chk("rdreg32 data", q_rd[2], 32'h0);
      chk("rdreg31", q_rd[3], 32'h1000_020F);

      // memory readback and errors
      clr_obs();
      issue(C_RDMEM, 32'h40, 32'h0);
      wait_idle();
      chk("rdmem data", q_rd[0], 32'h1234);
      chk("rdmem latency", q_rcyc[0] - last_acc, 32'd5);
      clr_obs();
      issue(C_RDMEM, 32'h41, 32'h0);
      issue(3'b110, 32'h0, 32'h0);
      issue(3'b111, 32'h0, 32'h0);
      issue(C_LOAD, 32'h102, 32'h3333_0000);
      wait_idle();
      chk("rdmem41 err", {31'b0, q_err[0]}, 32'h1);
      chk("cmd110 err", {31'b0, q_err[1]}, 32'h1);
      chk("cmd111 err", {31'b0, q_err[2]}, 32'h1);
      chk("load misaligned err", {31'b0, q_err[3]}, 32'h1);
      chk("error responses latency", q_rcyc[3] - last_acc, 32'd2);

      // pointer wrap
      clr_obs();
      issue(C_LOAD, 32'hFFFF_FFFC, 32'h4444_0000);
      issue(C_LDNX, 32'h0, 32'h4444_0001);
      wait_idle();
      chk("wrap addr0", q_ia[0], 32'hFFFF_FFFC);
      chk("wrap addr1", q_ia[1], 32'h0);

      // reset during MEMWAIT while running
      issue(C_RUN, 32'h0, 32'h0);
      issue(C_RDMEM, 32'h80, 32'h0);
      @(posedge clk); #1;
      clr_obs();
      hard_reset();
      release_reset();
      repeat (6) @(posedge clk);
      #1;
      chk("aborted no response", q_rd.size(), 32'd0);
      clr_obs();
      issue(C_LDNX, 32'h0, 32'h5555_0000);
      wait_idle();
      chk("post-reset ptr", q_ia[0], 32'h0);
      chk("post-reset err", {31'b0, q_err[0]}, 32'h0);

      repeat (2) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
